// File: rtl/port_prioritizer.sv
// Request-side port prioritizer: orders three port requests into three tagged
// slots (round-robin or fixed priority) behind one registered valid/ready stage.
module port_prioritizer #(
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fixed_prio,
  input  logic              port1_valid_in,
  input  logic              port1_wen,
  input  logic [ADDR_W-1:0] port1_addr,
  input  logic [15:0]       port1_data_in,
  input  logic              port2_valid_in,
  input  logic              port2_wen,
  input  logic [ADDR_W-1:0] port2_addr,
  input  logic [15:0]       port2_data_in,
  input  logic              port3_valid_in,
  input  logic              port3_wen,
  input  logic [ADDR_W-1:0] port3_addr,
  input  logic [15:0]       port3_data_in,
  output logic              in_ready,
  input  logic              out_ready,
  output logic              slot1_valid_out,
  output logic              slot1_wen,
  output logic [ADDR_W-1:0] slot1_addr,
  output logic [15:0]       slot1_data_out,
  output logic [1:0]        slot1_orig_id,
  output logic              slot2_valid_out,
  output logic              slot2_wen,
  output logic [ADDR_W-1:0] slot2_addr,
  output logic [15:0]       slot2_data_out,
  output logic [1:0]        slot2_orig_id,
  output logic              slot3_valid_out,
  output logic              slot3_wen,
  output logic [ADDR_W-1:0] slot3_addr,
  output logic [15:0]       slot3_data_out,
  output logic [1:0]        slot3_orig_id,
  output logic [1:0]        rr_ptr,
  output logic              full
);

  // Handshake: the input side transfers on in_ready & any valid, the output
  // bundle is consumed on full & out_ready; both may happen on the same edge.

  logic [2:0]        p_valid;
  logic [2:0]        p_wen;
  logic [ADDR_W-1:0] p_addr [3];
  logic [15:0]       p_data [3];

  assign p_valid = {port3_valid_in, port2_valid_in, port1_valid_in};
  assign p_wen   = {port3_wen, port2_wen, port1_wen};
  assign p_addr[0] = port1_addr;
  assign p_addr[1] = port2_addr;
  assign p_addr[2] = port3_addr;
  assign p_data[0] = port1_data_in;
  assign p_data[1] = port2_data_in;
  assign p_data[2] = port3_data_in;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  logic [1:0] base;
  logic [1:0] prio [3];
  logic [2:0] pv;
  logic [1:0] pos  [3];
  logic [1:0] sel  [3];
  logic       any_valid;
  logic [1:0] rr_next;

  always_comb begin
    base    = fixed_prio ? 2'd0 : rr_ptr;
    prio[0] = base;
    prio[1] = inc3(base);
    prio[2] = inc3(inc3(base));
    // pv[2] is the highest-priority port's valid
    pv = {p_valid[prio[0]], p_valid[prio[1]], p_valid[prio[2]]};
    pos[0] = 2'd0;
    pos[1] = 2'd1;
    pos[2] = 2'd2;
    // Stable partition: valid ports first, then invalid, each in priority order
    case (pv)
      3'b101: begin pos[0] = 2'd0; pos[1] = 2'd2; pos[2] = 2'd1; end
      3'b011: begin pos[0] = 2'd1; pos[1] = 2'd2; pos[2] = 2'd0; end
      3'b010: begin pos[0] = 2'd1; pos[1] = 2'd0; pos[2] = 2'd2; end
      3'b001: begin pos[0] = 2'd2; pos[1] = 2'd0; pos[2] = 2'd1; end
      default: ;
    endcase
    for (int j = 0; j < 3; j++) begin
      sel[j] = prio[pos[j]];
    end
    any_valid = |p_valid;
    rr_next   = inc3(sel[0]);
  end

  assign in_ready = !full || out_ready;

  logic [2:0]        s_valid;
  logic [2:0]        s_wen;
  logic [ADDR_W-1:0] s_addr [3];
  logic [15:0]       s_data [3];
  logic [1:0]        s_orig [3];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full    <= 1'b0;
      rr_ptr  <= 2'd0;
      s_valid <= '0;
      s_wen   <= '0;
      for (int j = 0; j < 3; j++) begin
        s_addr[j] <= '0;
        s_data[j] <= '0;
        s_orig[j] <= 2'(j + 1);
      end
    end else if (in_ready) begin
      // The permutation loads even with no valid input, so tags stay legal
      full <= any_valid;
      if (any_valid) begin
        rr_ptr <= rr_next;
      end
      for (int j = 0; j < 3; j++) begin
        s_valid[j] <= p_valid[sel[j]];
        s_wen[j]   <= p_wen[sel[j]];
        s_addr[j]  <= p_addr[sel[j]];
        s_data[j]  <= p_data[sel[j]];
        s_orig[j]  <= sel[j] + 2'd1;
      end
    end
  end

  assign slot1_valid_out = s_valid[0];
  assign slot1_wen       = s_wen[0];
  assign slot1_addr      = s_addr[0];
  assign slot1_data_out  = s_data[0];
  assign slot1_orig_id   = s_orig[0];
  assign slot2_valid_out = s_valid[1];
  assign slot2_wen       = s_wen[1];
  assign slot2_addr      = s_addr[1];
  assign slot2_data_out  = s_data[1];
  assign slot2_orig_id   = s_orig[1];
  assign slot3_valid_out = s_valid[2];
  assign slot3_wen       = s_wen[2];
  assign slot3_addr      = s_addr[2];
  assign slot3_data_out  = s_data[2];
  assign slot3_orig_id   = s_orig[2];

endmodule

// File: tb/tb_port_prioritizer.sv
// Self-checking bench for port_prioritizer: a reference ordering model fills an
// expected-bundle queue; each DUT bundle is popped and compared.
module tb_port_prioritizer;

  localparam int BW = 84;

  logic clk = 1'b0;
  logic rst;
  logic fixed_prio;
  logic out_ready;
  logic in_ready;
  logic [1:0] rr_ptr;
  logic full;

  logic       v [3];
  logic       w [3];
  logic [7:0] a [3];
  logic [15:0] d [3];

  logic       s1_v, s1_w, s2_v, s2_w, s3_v, s3_w;
  logic [7:0] s1_a, s2_a, s3_a;
  logic [15:0] s1_d, s2_d, s3_d;
  logic [1:0] s1_o, s2_o, s3_o;

  always #5 clk = ~clk;

  port_prioritizer #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .fixed_prio(fixed_prio),
    .port1_valid_in(v[0]), .port1_wen(w[0]), .port1_addr(a[0]), .port1_data_in(d[0]),
    .port2_valid_in(v[1]), .port2_wen(w[1]), .port2_addr(a[1]), .port2_data_in(d[1]),
    .port3_valid_in(v[2]), .port3_wen(w[2]), .port3_addr(a[2]), .port3_data_in(d[2]),
    .in_ready(in_ready), .out_ready(out_ready),
    .slot1_valid_out(s1_v), .slot1_wen(s1_w), .slot1_addr(s1_a), .slot1_data_out(s1_d), .slot1_orig_id(s1_o),
    .slot2_valid_out(s2_v), .slot2_wen(s2_w), .slot2_addr(s2_a), .slot2_data_out(s2_d), .slot2_orig_id(s2_o),
    .slot3_valid_out(s3_v), .slot3_wen(s3_w), .slot3_addr(s3_a), .slot3_data_out(s3_d), .slot3_orig_id(s3_o),
    .rr_ptr(rr_ptr), .full(full)
  );

  logic [BW-1:0] got_bundle;
  assign got_bundle = {s3_v, s3_w, s3_a, s3_d, s3_o,
                       s2_v, s2_w, s2_a, s2_d, s2_o,
                       s1_v, s1_w, s1_a, s1_d, s1_o};

  logic [BW-1:0] exp_q [$];
  logic [BW-1:0] m_hold;
  logic [BW-1:0] reset_bundle;
  logic          m_full;
  int            m_rr;
  int            n_cmp = 0;
  int            n_err = 0;

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference ordering: walk the priority list twice, valid ports then invalid ones
  task automatic model(output logic [BW-1:0] b, output int winner);
    int order [3];
    int slots [$];
    int start;
    int p;
    start = fixed_prio ? 0 : m_rr;
    for (int i = 0; i < 3; i++) order[i] = (start + i) % 3;
    for (int i = 0; i < 3; i++) if (v[order[i]]) slots.push_back(order[i]);
    for (int i = 0; i < 3; i++) if (!v[order[i]]) slots.push_back(order[i]);
    b = '0;
    for (int s = 0; s < 3; s++) begin
      p = slots[s];
      b[s*28 +: 28] = {v[p], w[p], a[p], d[p], 2'(p + 1)};
    end
    winner = slots[0];
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_full = 1'b0;
    m_rr   = 0;
    m_hold = reset_bundle;
  endtask

  // Called just after a falling edge with inputs already set
  task automatic step(input logic oready);
    logic [BW-1:0] b;
    int winner;
    logic m_ready;
    logic perm_ok;
    logic loaded;
    out_ready = oready;
    #1;
    m_ready = !m_full || oready;
    check("in_ready", BW'(in_ready), BW'(m_ready));
    loaded = 1'b0;
    if (m_ready) begin
      model(b, winner);
      exp_q.push_back(b);
      loaded = 1'b1;
      m_full = v[0] || v[1] || v[2];
      if (m_full) m_rr = (winner + 1) % 3;
    end
    @(posedge clk);
    @(negedge clk);
    if (loaded) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL scoreboard_empty got=0 exp=1");
      end else begin
        m_hold = exp_q.pop_front();
      end
    end
    check("bundle", got_bundle, m_hold);
    check("rr_ptr", BW'(rr_ptr), BW'(m_rr));
    check("full", BW'(full), BW'(m_full));
    perm_ok = (s1_o != 0) && (s2_o != 0) && (s3_o != 0) &&
              (s1_o != s2_o) && (s2_o != s3_o) && (s1_o != s3_o);
    check("orig_perm", BW'(perm_ok), BW'(1'b1));
  endtask

  task automatic set_port(input int p, input logic vv, input logic ww,
                          input logic [7:0] aa, input logic [15:0] dd);
    v[p] = vv;
    w[p] = ww;
    a[p] = aa;
    d[p] = dd;
  endtask

  task automatic rand_ports();
    for (int p = 0; p < 3; p++) begin
      set_port(p, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               8'($urandom_range(0, 255)), 16'($urandom_range(0, 65535)));
    end
  endtask

  initial begin
    logic [1:0] exp_s1 [3];
    reset_bundle = {1'b0, 1'b0, 8'h00, 16'h0000, 2'd3,
                    1'b0, 1'b0, 8'h00, 16'h0000, 2'd2,
                    1'b0, 1'b0, 8'h00, 16'h0000, 2'd1};
    rst = 1'b1;
    fixed_prio = 1'b0;
    out_ready = 1'b1;
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 1'b0, 8'h00, 16'h0000);
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_bundle", got_bundle, reset_bundle);
    check("reset_in_ready", BW'(in_ready), BW'(1'b1));
    check("reset_rr", BW'(rr_ptr), BW'(0));
    rst = 1'b0;

    // Round-robin with all three ports valid
    exp_s1[0] = 2'd1; exp_s1[1] = 2'd2; exp_s1[2] = 2'd3;
    for (int c = 0; c < 3; c++) begin
      for (int p = 0; p < 3; p++)
        set_port(p, 1'b1, 1'(p & 1), 8'(8'h10 * (c + 1) + p), 16'(16'h1000 * (p + 1) + c));
      step(1'b1);
      check("rr_slot1_id", BW'(s1_o), BW'(exp_s1[c]));
      check("rr_slot2_id", BW'(s2_o), BW'((c + 1) % 3 + 1));
      check("rr_slot3_id", BW'(s3_o), BW'((c + 2) % 3 + 1));
    end

    // Only port3 valid
    set_port(0, 1'b0, 1'b0, 8'h11, 16'h1111);
    set_port(1, 1'b0, 1'b1, 8'h22, 16'h2222);
    set_port(2, 1'b1, 1'b1, 8'h5A, 16'hBEEF);
    step(1'b1);
    check("p3_slot1", BW'({s1_v, s1_w, s1_a, s1_d, s1_o}), BW'({1'b1, 1'b1, 8'h5A, 16'hBEEF, 2'd3}));
    check("p3_other_valid", BW'({s2_v, s3_v}), BW'(2'b00));
    check("p3_rr", BW'(rr_ptr), BW'(0));

    // Stall: bundle held while inputs churn, then a new bundle loads on release
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b0, 8'(8'hA0 + p), 16'(16'hA000 + p));
    step(1'b0);
    for (int c = 0; c < 4; c++) begin
      rand_ports();
      step(1'b0);
      check("stall_in_ready", BW'(in_ready), BW'(1'b0));
    end
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b1, 8'(8'hB0 + p), 16'(16'hB000 + p));
    step(1'b1);
    check("release_slot1_addr_hi", BW'(s1_a[7:4]), BW'(4'hB));

    // Fixed priority with ports 2 and 3 valid
    fixed_prio = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_port(0, 1'b0, 1'b1, 8'(8'hC0 + c), 16'(16'hC000 + c));
      set_port(1, 1'b1, 1'b0, 8'(8'hD0 + c), 16'(16'hD000 + c));
      set_port(2, 1'b1, 1'b1, 8'(8'hE0 + c), 16'(16'hE000 + c));
      step(1'b1);
      check("fixed_ids", BW'({s1_o, s2_o, s3_o}), BW'({2'd2, 2'd3, 2'd1}));
      check("fixed_slot3_valid", BW'(s3_v), BW'(1'b0));
    end
    fixed_prio = 1'b0;

    // Random traffic with random backpressure and policy changes
    for (int c = 0; c < 1000; c++) begin
      rand_ports();
      if ($urandom_range(0, 15) == 0) fixed_prio = ~fixed_prio;
      step(1'($urandom_range(0, 3) != 0));
    end

    // Reset asserted mid-stall takes effect without a clock edge
    fixed_prio = 1'b0;
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 1'b1, 8'(8'h70 + p), 16'(16'h7000 + p));
    step(1'b1);
    rand_ports();
    step(1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("async_reset_bundle", got_bundle, reset_bundle);
    check("async_reset_in_ready", BW'(in_ready), BW'(1'b1));
    check("async_reset_rr", BW'(rr_ptr), BW'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 1'b0, 8'h00, 16'h0000);
    set_port(1, 1'b1, 1'b0, 8'h3C, 16'h1234);
    step(1'b1);
    check("post_reset_slot1_id", BW'(s1_o), BW'(2'd2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/port_prioritizer.md
# port_prioritizer

Request-side companion to the response-side port restorer of the triple-ported memory: it takes the three external port requests, orders them into three priority slots for the memory core, and tags each slot with the originating port ID. The response path uses these tags to return data to the correct external port. It is a single registered stage with a valid/ready handshake and a rotating (round-robin) or fixed priority policy.

## Interface
Parameters:
- ADDR_W, 8, address width of every port request.

Ports (clock and reset first):
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- fixed_prio  input  1  1 = fixed order port1 > port2 > port3; 0 = round-robin.
- portN_valid_in  input  1  (N = 1,2,3) request present on port N.
- portN_wen  input  1  write enable of port N request.
- portN_addr  input  ADDR_W  address of port N request.
- portN_data_in  input  16  write data of port N request.
- in_ready  output  1  stage can accept this cycle; the same signal applies to all three ports.
- out_ready  input  1  memory core accepts the slot bundle this cycle.
- slotN_valid_out  output  1  (N = 1,2,3) slot N holds a valid request.
- slotN_wen  output  1  write enable in slot N.
- slotN_addr  output  ADDR_W  address in slot N.
- slotN_data_out  output  16  write data in slot N.
- slotN_orig_id  output  2  originating port of slot N: ORIG_PORT_1_ID = 2'd1, ORIG_PORT_2_ID = 2'd2, ORIG_PORT_3_ID = 2'd3. 2'd0 never appears after reset.

## Operation
- Priority order: rr_ptr ∈ {0,1,2} (0 = port1). The order is rr_ptr, rr_ptr+1, rr_ptr+2, taken mod 3. When fixed_prio=1, the order is always 1,2,3 and rr_ptr is ignored; rr_ptr still updates.
- Compaction: valid requests fill slot1, slot2, … in priority order. Invalid ports fill the remaining slots, also in priority order. The slotN_orig_id triple is therefore always a full permutation of {1,2,3}, even when some or all inputs are invalid.
- Each slot carries the valid, wen, addr, and data of its assigned port. Fields of invalid ports are copied unmodified; they are not zeroed.
- Accept: accept = in_ready & (any portN_valid_in). On accept, the output register loads the ordered bundle and full is set to 1.
- in_ready = !full | out_ready. If in_ready=1 and no input is valid, full clears on a drain and the permutation still loads.
- Drain: when full & out_ready, the bundle is consumed. Load and drain can happen in the same cycle, so a new bundle replaces the old one with no bubble.
- Stall: when full & !out_ready, every output is held bit-stable and in_ready=0.
- rr_ptr update: on accept, rr_ptr moves to (ID of the port granted slot1) mod 3, i.e. the port after the slot1 winner. Otherwise rr_ptr holds. A port that wins slot1 becomes lowest priority on the next accept.
- The set of six legal orig_id permutations matches the response-side restorer exactly. Any other triple is a design bug.

## Timing
- Reset (async assert, released synchronously to clk):
  - all slotN_valid_out = 0, slotN_wen = 0, addr = 0, data = 0;
  - slot1/2/3_orig_id = 1/2/3;
  - full = 0, so in_ready = 1;
  - rr_ptr = 0.
- Latency: 1 cycle. Inputs sampled at edge k appear on slot outputs after edge k.
- Throughput: 1 bundle per cycle while out_ready=1.
- Reset asserted mid-stall: the pending bundle is discarded, outputs go to reset values immediately (asynchronously), and rr_ptr returns to 0.
- Changing fixed_prio affects the next accepted bundle only; a held bundle is never reordered.
- Wrap: rr_ptr advances 2 → 0. It never takes the value 3.

## Test plan
- Reset check: assert rst mid-traffic -> outputs drop to 0 within the same cycle, orig_ids = 1,2,3, in_ready = 1, rr_ptr = 0.
- All three valid, out_ready=1, round-robin, 3 consecutive cycles:
  - slot1 orig_id sequence = 1, 2, 3;
  - first bundle orig_ids = (1,2,3), second = (2,3,1), third = (3,1,2).
- Only port3 valid, addr 8'h5A, data 16'hBEEF, wen=1 -> next cycle slot1 = port3 (orig_id 3, addr 5A, data BEEF, valid 1), slot2/slot3 valid = 0, rr_ptr = 0.
- Stall: load bundle A, hold out_ready=0 for 4 cycles while changing inputs -> outputs stay equal to A and in_ready=0. Raise out_ready -> bundle B loads on the same edge.
- fixed_prio=1 with ports 2 and 3 valid over 3 cycles -> always slot1 = 2, slot2 = 3, slot3 orig_id = 1 with valid 0.
- Round trip: feed slot outputs with memory-model responses through the response-side restorer, using random valids over 1000 cycles -> every response returns on its originating port and no orig_id triple falls outside the six legal permutations.
